bus_cmd_master: RTL and testbench
=================================

Name: bus_cmd_master

Overview:
- Bus initiator for the lab's 32-bit word-addressed register bus.
- Converts a simple command, write-data and read-data stream interface into WR_ADDR/WR_DATA/WR_BACK and RD_ADDR/RD_DATA channel transactions toward a slave, for example the logic-analyzer register file.
- Used by the host-side bridge to arm captures and poll status.
- Runs one transaction at a time; INCR bursts only.

Parameters:
ID_VAL, 4'h0, constant issued on MASTER_WR_ADDR_ID and MASTER_RD_ADDR_ID.
TIMEOUT_CYCLES, 1024, watchdog limit; used only when the optional feature is compiled in.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid is also high
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  32  start word address
cmd_len  in  8  beats minus 1
wdata_valid  in  1  write beat offered
wdata_ready  out  1  write beat accepted
wdata  in  32  write data
wstrb  in  4  byte strobes
rdata_valid  out  1  read beat offered
rdata_ready  in  1  read beat accepted
rdata  out  32  read data
rdata_last  out  1  final read beat
done_pulse  out  1  one-cycle transaction-complete pulse
done_resp  out  2  worst response of the transaction; 00 OK, 10 SLVERR, 11 timeout
busy  out  1  high whenever the FSM is not in IDLE
MASTER_WR_ADDR_ID/_ADDR/_LEN/_BURST/_VALID  out  4/32/8/2/1  write address channel
MASTER_WR_ADDR_READY  in  1  write address ready
MASTER_WR_DATA/_STRB/_LAST/_VALID  out  32/4/1/1  write data channel
MASTER_WR_DATA_READY  in  1  write data ready
MASTER_WR_BACK_ID/_RESP/_VALID  in  4/2/1  write response
MASTER_WR_BACK_READY  out  1  write response ready
MASTER_RD_ADDR_ID/_ADDR/_LEN/_BURST/_VALID  out  4/32/8/2/1  read address channel
MASTER_RD_ADDR_READY  in  1  read address ready
MASTER_RD_BACK_ID/_DATA/_RESP/_LAST/_VALID  in  4/32/2/1/1  read data channel
MASTER_RD_DATA_READY  out  1  read data ready

Behaviour:
- Reset values while rst is high:
  - FSM in IDLE.
  - All *_VALID outputs, cmd_ready, wdata_ready, rdata_valid, done_pulse and busy are 0.
  - Latched address/len cleared; error accumulator cleared.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/len/write and go to WA (write) or RA (read).
  - WA: WR_ADDR_VALID=1 with latched addr, LEN=len, BURST=2'b01. Go to WD on WR_ADDR_READY.
  - WD: MASTER_WR_DATA_VALID = wdata_valid and wdata_ready = MASTER_WR_DATA_READY, a combinational pass-through.
    - Beat counter increments per handshake.
    - WR_DATA_LAST = (count == len).
    - Handshake with LAST goes to WB.
  - WB: WR_BACK_READY=1. On WR_BACK_VALID, record RESP and go to FIN.
  - RA: RD_ADDR_VALID=1, LEN=len, BURST=2'b01. Go to RD on RD_ADDR_READY.
  - RD: rdata_valid = RD_DATA_VALID and MASTER_RD_DATA_READY = rdata_ready, pass-through.
    - rdata and rdata_last are forwarded unchanged.
    - Any RESP != 00 sets the error accumulator.
    - Handshake with slave LAST goes to FIN.
  - FIN: done_pulse=1 for exactly one cycle, done_resp = accumulated value; go to IDLE.
- Timing:
  - Address valid asserts on the cycle after command accept.
  - A new command is accepted no earlier than the cycle after FIN.
- Address valids are registered and stay high until READY; they never drop while waiting.
- Error accumulation: done_resp = OR of all responses observed; write uses BACK_RESP, read uses every beat's RESP.
- Slave asserts RD LAST before len+1 beats: accept it and finish; done_resp=10.
- Slave gives no LAST after len+1 beats: keep accepting beats until LAST.
- cmd_len=0 is a single beat: LAST is asserted on the first beat.
- Beat counter is 8 bits and wraps only past 255; len max 255 means 256 beats.
- Mismatched BACK_ID or RD_BACK_ID: treated as SLVERR (10) and the transaction still completes.
- rst asserted mid-transaction: immediate return to IDLE with all valids dropped; no done_pulse.

Optional Feature:
- Macro: BUS_CMD_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit watchdog counts cycles spent in any state other than IDLE/FIN without a handshake.
  - The counter resets on every handshake.
  - On reaching TIMEOUT_CYCLES, all valids/readies drop, the FSM goes to FIN, and done_resp=11.
- Without the macro: no watchdog logic is present; the FSM waits indefinitely.

Decomposition:
- Shared package bus_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_TIMEOUT=2'b11.
  - BURST_FIXED=2'b00, BURST_INCR=2'b01.
  - The master FSM state enum typedef.
- No sub-module; the watchdog is inline under the macro.

Test Plan:
- Write addr 0x2, len 0, data 0x0000_0040, strb 4'hF, slave OK -> exactly one WR_ADDR and one WR_DATA with LAST=1; done_pulse with done_resp=00.
- Read addr 0x10, len 7 (0x10-0x17), rdata_ready toggled 50% -> 8 beats delivered in order, rdata_last only on the 8th, no beat lost; done_resp=00.
- Slave WR_BACK_RESP=10 -> done_resp=10; next command accepted 2 cycles after BACK handshake.
- Read len 3, slave RESP=10 on beat 2 only -> all 4 beats delivered; done_resp=10.
- With BUS_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, WR_ADDR_READY held low -> valid drops after 16 cycles, done_resp=11, busy=0 the following cycle.
- rst pulsed during RD beat 3 of 8 -> busy=0, all valids=0 next cycle, no done_pulse; a new read then completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the lab's 32-bit word-addressed register bus:
// response codes, burst types and the bus_cmd_master FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam logic [1:0] BURST_FIXED  = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WA   = 3'd1,
    ST_WD   = 3'd2,
    ST_WB   = 3'd3,
    ST_RA   = 3'd4,
    ST_RD   = 3'd5,
    ST_FIN  = 3'd6
  } mst_state_e;

endpackage

// File: rtl/bus_cmd_master.sv
// ---------------------------------------------------------------------------
// bus_cmd_master
// Bus initiator: turns a command / write-data / read-data stream interface
// into WR_ADDR/WR_DATA/WR_BACK and RD_ADDR/RD_DATA channel transactions.
// One transaction at a time, INCR bursts only.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_*                    command stream (write flag, start addr, len-1)
//   wdata_*, wstrb           write beat stream (passed through to WR_DATA)
//   rdata_*                  read beat stream (passed through from RD_BACK)
//   done_pulse, done_resp    one-cycle completion pulse + worst response
//   busy                     FSM not in IDLE
//   MASTER_WR_ADDR_*         write address channel
//   MASTER_WR_DATA_*         write data channel
//   MASTER_WR_BACK_*         write response channel
//   MASTER_RD_ADDR_*         read address channel
//   MASTER_RD_BACK_*, MASTER_RD_DATA_READY   read data channel
//
// Optional feature: define BUS_CMD_MASTER_TIMEOUT_EN to add a watchdog that
// forces the transaction to FIN with done_resp=11 after TIMEOUT_CYCLES cycles
// without a handshake. Without it the FSM waits indefinitely.
// ---------------------------------------------------------------------------
module bus_cmd_master
  import bus_pkg::*;
#(
  parameter logic [3:0] ID_VAL         = 4'h0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        done_pulse,
  output logic [1:0]  done_resp,
  output logic        busy,
  output logic [3:0]  MASTER_WR_ADDR_ID,
  output logic [31:0] MASTER_WR_ADDR_ADDR,
  output logic [7:0]  MASTER_WR_ADDR_LEN,
  output logic [1:0]  MASTER_WR_ADDR_BURST,
  output logic        MASTER_WR_ADDR_VALID,
  input  logic        MASTER_WR_ADDR_READY,
  output logic [31:0] MASTER_WR_DATA,
  output logic [3:0]  MASTER_WR_DATA_STRB,
  output logic        MASTER_WR_DATA_LAST,
  output logic        MASTER_WR_DATA_VALID,
  input  logic        MASTER_WR_DATA_READY,
  input  logic [3:0]  MASTER_WR_BACK_ID,
  input  logic [1:0]  MASTER_WR_BACK_RESP,
  input  logic        MASTER_WR_BACK_VALID,
  output logic        MASTER_WR_BACK_READY,
  output logic [3:0]  MASTER_RD_ADDR_ID,
  output logic [31:0] MASTER_RD_ADDR_ADDR,
  output logic [7:0]  MASTER_RD_ADDR_LEN,
  output logic [1:0]  MASTER_RD_ADDR_BURST,
  output logic        MASTER_RD_ADDR_VALID,
  input  logic        MASTER_RD_ADDR_READY,
  input  logic [3:0]  MASTER_RD_BACK_ID,
  input  logic [31:0] MASTER_RD_BACK_DATA,
  input  logic [1:0]  MASTER_RD_BACK_RESP,
  input  logic        MASTER_RD_BACK_LAST,
  input  logic        MASTER_RD_BACK_VALID,
  output logic        MASTER_RD_DATA_READY
);

  mst_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  // Set once a read has delivered len+1 beats without LAST, so a late LAST
  // is not mistaken for an early one after the beat counter moves past len.
  logic        over_q, over_d;
  logic        wr_addr_valid_q, rd_addr_valid_q;
  logic        hs;

`ifdef BUS_CMD_MASTER_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        timeout_hit;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    len_d                = len_q;
    cnt_d                = cnt_q;
    err_d                = err_q;
    over_d               = over_q;
    hs                   = 1'b0;
    cmd_ready            = 1'b0;
    wdata_ready          = 1'b0;
    MASTER_WR_DATA_VALID = 1'b0;
    MASTER_WR_BACK_READY = 1'b0;
    rdata_valid          = 1'b0;
    MASTER_RD_DATA_READY = 1'b0;
    done_pulse           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 8'd0;
          err_d   = RESP_OKAY;
          over_d  = 1'b0;
          state_d = cmd_write ? ST_WA : ST_RA;
        end
      end
      ST_WA: begin
        hs = wr_addr_valid_q && MASTER_WR_ADDR_READY;
        if (hs) state_d = ST_WD;
      end
      ST_WD: begin
        MASTER_WR_DATA_VALID = wdata_valid;
        wdata_ready          = MASTER_WR_DATA_READY;
        hs = wdata_valid && MASTER_WR_DATA_READY;
        if (hs) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = ST_WB;
        end
      end
      ST_WB: begin
        MASTER_WR_BACK_READY = 1'b1;
        hs = MASTER_WR_BACK_VALID;
        if (hs) begin
          err_d = err_q | MASTER_WR_BACK_RESP;
          if (MASTER_WR_BACK_ID != ID_VAL) err_d = err_d | RESP_SLVERR;
          state_d = ST_FIN;
        end
      end
      ST_RA: begin
        hs = rd_addr_valid_q && MASTER_RD_ADDR_READY;
        if (hs) state_d = ST_RD;
      end
      ST_RD: begin
        rdata_valid          = MASTER_RD_BACK_VALID;
        MASTER_RD_DATA_READY = rdata_ready;
        hs = MASTER_RD_BACK_VALID && rdata_ready;
        if (hs) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) over_d = 1'b1;
          err_d = err_q | MASTER_RD_BACK_RESP;
          if (MASTER_RD_BACK_ID != ID_VAL) err_d = err_d | RESP_SLVERR;
          if (MASTER_RD_BACK_LAST) begin
            // LAST before len+1 beats is a protocol error from the slave.
            if (!over_q && (cnt_q != len_q)) err_d = err_d | RESP_SLVERR;
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        done_pulse = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef BUS_CMD_MASTER_TIMEOUT_EN
    // Watchdog: counts stalled cycles in active states, cleared by any handshake.
    if ((state_q == ST_IDLE) || (state_q == ST_FIN) || hs) begin
      wd_d = 16'd0;
    end else begin
      wd_d = wd_q + 16'd1;
    end
    timeout_hit = (state_q != ST_IDLE) && (state_q != ST_FIN) && !hs &&
                  (wd_q == 16'(TIMEOUT_CYCLES - 1));
    if (timeout_hit) begin
      state_d = ST_FIN;
      err_d   = RESP_TIMEOUT;
      wd_d    = 16'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= 32'd0;
      len_q           <= 8'd0;
      cnt_q           <= 8'd0;
      err_q           <= RESP_OKAY;
      over_q          <= 1'b0;
      wr_addr_valid_q <= 1'b0;
      rd_addr_valid_q <= 1'b0;
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
      wd_q            <= 16'd0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      over_q          <= over_d;
      // Address valids are registered images of the next state, so they rise
      // the cycle after command accept and hold until the READY handshake.
      wr_addr_valid_q <= (state_d == ST_WA);
      rd_addr_valid_q <= (state_d == ST_RA);
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
      wd_q            <= wd_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done_resp = err_q;

  assign MASTER_WR_ADDR_ID    = ID_VAL;
  assign MASTER_WR_ADDR_ADDR  = addr_q;
  assign MASTER_WR_ADDR_LEN   = len_q;
  assign MASTER_WR_ADDR_BURST = BURST_INCR;
  assign MASTER_WR_ADDR_VALID = wr_addr_valid_q;

  assign MASTER_WR_DATA       = wdata;
  assign MASTER_WR_DATA_STRB  = wstrb;
  assign MASTER_WR_DATA_LAST  = (cnt_q == len_q);

  assign MASTER_RD_ADDR_ID    = ID_VAL;
  assign MASTER_RD_ADDR_ADDR  = addr_q;
  assign MASTER_RD_ADDR_LEN   = len_q;
  assign MASTER_RD_ADDR_BURST = BURST_INCR;
  assign MASTER_RD_ADDR_VALID = rd_addr_valid_q;

  assign rdata      = MASTER_RD_BACK_DATA;
  assign rdata_last = MASTER_RD_BACK_LAST;

endmodule

// File: tb/tb_bus_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_bus_cmd_master
// Directed bench for bus_cmd_master. The bench plays both the host side and
// the slave side; inputs change on the falling edge, outputs are sampled
// 1 time unit later, handshakes complete on the rising edge.
// With BUS_CMD_MASTER_TIMEOUT_EN defined it also exercises the watchdog
// (TIMEOUT_CYCLES = 16).
// ---------------------------------------------------------------------------
module tb_bus_cmd_master;

  localparam logic [3:0] ID = 4'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rdata_valid, rdata_ready;
  logic [31:0] rdata;
  logic        rdata_last, done_pulse, busy;
  logic [1:0]  done_resp;
  logic [3:0]  wa_id;
  logic [31:0] wa_addr;
  logic [7:0]  wa_len;
  logic [1:0]  wa_burst;
  logic        wa_valid, wa_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        wd_last, wd_valid, wd_ready;
  logic [3:0]  wb_id;
  logic [1:0]  wb_resp;
  logic        wb_valid, wb_ready;
  logic [3:0]  ra_id;
  logic [31:0] ra_addr;
  logic [7:0]  ra_len;
  logic [1:0]  ra_burst;
  logic        ra_valid, ra_ready;
  logic [3:0]  rb_id;
  logic [31:0] rb_data;
  logic [1:0]  rb_resp;
  logic        rb_last, rb_valid, rd_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_cmd_master #(.ID_VAL(ID), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .done_pulse(done_pulse), .done_resp(done_resp), .busy(busy),
    .MASTER_WR_ADDR_ID(wa_id), .MASTER_WR_ADDR_ADDR(wa_addr), .MASTER_WR_ADDR_LEN(wa_len),
    .MASTER_WR_ADDR_BURST(wa_burst), .MASTER_WR_ADDR_VALID(wa_valid), .MASTER_WR_ADDR_READY(wa_ready),
    .MASTER_WR_DATA(wd_data), .MASTER_WR_DATA_STRB(wd_strb), .MASTER_WR_DATA_LAST(wd_last),
    .MASTER_WR_DATA_VALID(wd_valid), .MASTER_WR_DATA_READY(wd_ready),
    .MASTER_WR_BACK_ID(wb_id), .MASTER_WR_BACK_RESP(wb_resp), .MASTER_WR_BACK_VALID(wb_valid),
    .MASTER_WR_BACK_READY(wb_ready),
    .MASTER_RD_ADDR_ID(ra_id), .MASTER_RD_ADDR_ADDR(ra_addr), .MASTER_RD_ADDR_LEN(ra_len),
    .MASTER_RD_ADDR_BURST(ra_burst), .MASTER_RD_ADDR_VALID(ra_valid), .MASTER_RD_ADDR_READY(ra_ready),
    .MASTER_RD_BACK_ID(rb_id), .MASTER_RD_BACK_DATA(rb_data), .MASTER_RD_BACK_RESP(rb_resp),
    .MASTER_RD_BACK_LAST(rb_last), .MASTER_RD_BACK_VALID(rb_valid), .MASTER_RD_DATA_READY(rd_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write transaction. Entered and left at a falling edge (+1).
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] dbase, input logic [3:0] bid,
                          input logic [1:0] bresp, input logic [1:0] exp_resp);
    int i;
    int cyc;
    logic [31:0] exp_d;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len; #1;
    check("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("wr_addr_valid", 32'(wa_valid), 32'd1);
    check("wr_addr_addr", wa_addr, addr);
    check("wr_addr_len", 32'(wa_len), 32'(len));
    check("wr_addr_burst", 32'(wa_burst), 32'd1);
    check("wr_addr_id", 32'(wa_id), 32'(ID));
    check("wr_no_rd_addr", 32'(ra_valid), 32'd0);
    @(negedge clk); #1;
    check("wr_addr_hold", 32'(wa_valid), 32'd1);
    wa_ready = 1'b1;
    @(negedge clk); wa_ready = 1'b0; #1;
    check("wr_addr_drop", 32'(wa_valid), 32'd0);
    i = 0; cyc = 0;
    while (i < int'(len) + 1 && cyc < 1000) begin
      exp_d = dbase + 32'(i);
      wdata_valid = 1'b1; wdata = exp_d; wstrb = 4'hF; wd_ready = cyc[0] | (len == 8'd0); #1;
      check("wr_data_valid", 32'(wd_valid), 32'd1);
      check("wr_data_ready_pass", 32'(wdata_ready), 32'(wd_ready));
      if (wd_ready) begin
        check("wr_data", wd_data, exp_d);
        check("wr_strb", 32'(wd_strb), 32'hF);
        check("wr_last", 32'(wd_last), 32'(i == int'(len)));
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    check("wr_beats", 32'(i), 32'(int'(len) + 1));
    wdata_valid = 1'b0; wd_ready = 1'b0; #1;
    check("wr_back_ready", 32'(wb_ready), 32'd1);
    check("wr_data_idle", 32'(wd_valid), 32'd0);
    wb_valid = 1'b1; wb_resp = bresp; wb_id = bid;
    @(negedge clk); wb_valid = 1'b0; wb_resp = 2'b00; wb_id = ID; #1;
    check("wr_done_pulse", 32'(done_pulse), 32'd1);
    check("wr_done_resp", 32'(done_resp), 32'(exp_resp));
    check("wr_fin_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); #1;
    check("wr_done_once", 32'(done_pulse), 32'd0);
    check("wr_busy_clear", 32'(busy), 32'd0);
  endtask

  // Read transaction; the slave returns nbeats beats with LAST on the final
  // one, SLVERR on beat err_beat, and the bench pulses rst on beat rst_beat.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                         input int err_beat, input int rst_beat, input logic [1:0] exp_resp);
    int i;
    int cyc;
    logic [31:0] exp_d;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len; #1;
    check("rd_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("rd_addr_valid", 32'(ra_valid), 32'd1);
    check("rd_addr_addr", ra_addr, addr);
    check("rd_addr_len", 32'(ra_len), 32'(len));
    check("rd_addr_burst", 32'(ra_burst), 32'd1);
    check("rd_busy", 32'(busy), 32'd1);
    ra_ready = 1'b1;
    @(negedge clk); ra_ready = 1'b0; #1;
    check("rd_addr_drop", 32'(ra_valid), 32'd0);
    i = 0; cyc = 0;
    while (i < nbeats && cyc < 1000) begin
      exp_d = 32'hA500_0000 ^ (addr + 32'(i));
      rb_valid = 1'b1; rb_data = exp_d; rb_last = (i == nbeats - 1); rb_id = ID;
      rb_resp = (i == err_beat) ? 2'b10 : 2'b00;
      rdata_ready = cyc[0];
      if (i == rst_beat) begin
        rst = 1'b1; rdata_ready = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_addr_valid", 32'(ra_valid), 32'd0);
        check("rst_wr_addr_valid", 32'(wa_valid), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_no_done", 32'(done_pulse), 32'd0);
        rb_valid = 1'b0; rdata_ready = 1'b0;
        @(negedge clk); #1;
        check("rst_no_done_later", 32'(done_pulse), 32'd0);
        return;
      end
      #1;
      check("rd_valid_pass", 32'(rdata_valid), 32'd1);
      check("rd_ready_pass", 32'(rd_ready), 32'(rdata_ready));
      if (rdata_ready) begin
        check("rd_data", rdata, exp_d);
        check("rd_last", 32'(rdata_last), 32'(i == nbeats - 1));
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    check("rd_beats", 32'(i), 32'(nbeats));
    rb_valid = 1'b0; rb_last = 1'b0; rb_resp = 2'b00; rdata_ready = 1'b0; #1;
    check("rd_done_pulse", 32'(done_pulse), 32'd1);
    check("rd_done_resp", 32'(done_resp), 32'(exp_resp));
    check("rd_fin_valid", 32'(rdata_valid), 32'd0);
    @(negedge clk); #1;
    check("rd_done_once", 32'(done_pulse), 32'd0);
    check("rd_busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
    wdata_valid = 1'b0; wdata = 32'd0; wstrb = 4'h0; rdata_ready = 1'b0;
    wa_ready = 1'b0; wd_ready = 1'b0;
    wb_id = ID; wb_resp = 2'b00; wb_valid = 1'b0;
    ra_ready = 1'b0;
    rb_id = ID; rb_data = 32'd0; rb_resp = 2'b00; rb_last = 1'b0; rb_valid = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    $display("step: reset state");
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy0", 32'(busy), 32'd0);
    check("rst_wa_valid", 32'(wa_valid), 32'd0);
    check("rst_ra_valid", 32'(ra_valid), 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    check("rst_rdata_valid0", 32'(rdata_valid), 32'd0);
    @(negedge clk); rst = 1'b0; #1;

    $display("step: write 0x2 len 0 data 0x40 OK");
    do_write(32'h2, 8'd0, 32'h0000_0040, ID, 2'b00, 2'b00);
    $display("step: read 0x10 len 7, ready toggling");
    do_read(32'h10, 8'd7, 8, -1, -1, 2'b00);
    $display("step: write 0x20 len 1 slave SLVERR, then immediate read");
    do_write(32'h20, 8'd1, 32'h0000_0100, ID, 2'b10, 2'b10);
    $display("step: read 0x30 len 3 SLVERR on beat 2");
    do_read(32'h30, 8'd3, 4, 2, -1, 2'b10);
    $display("step: read 0x40 len 3 early LAST after 2 beats");
    do_read(32'h40, 8'd3, 2, -1, -1, 2'b10);
    $display("step: read 0x50 len 0 single beat");
    do_read(32'h50, 8'd0, 1, -1, -1, 2'b00);
    $display("step: read 0x60 len 1 late LAST after 3 beats");
    do_read(32'h60, 8'd1, 3, -1, -1, 2'b00);
    $display("step: write 0x70 len 2 mismatched BACK_ID");
    do_write(32'h70, 8'd2, 32'h1234_0000, 4'h3, 2'b00, 2'b10);
    $display("step: read 0x80 len 7 with rst on beat 3");
    do_read(32'h80, 8'd7, 8, -1, 2, 2'b00);
    $display("step: read 0x90 len 3 after reset");
    do_read(32'h90, 8'd3, 4, -1, -1, 2'b00);

`ifdef BUS_CMD_MASTER_TIMEOUT_EN
    begin
      int n;
      $display("step: write with WR_ADDR_READY stuck low (watchdog)");
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hA0; cmd_len = 8'd0; #1;
      check("to_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk); cmd_valid = 1'b0; #1;
      n = 0;
      while (wa_valid && n < 40) begin
        n++;
        @(negedge clk); #1;
      end
      check("to_valid_cycles", 32'(n), 32'd16);
      check("to_done_pulse", 32'(done_pulse), 32'd1);
      check("to_done_resp", 32'(done_resp), 32'd3);
      @(negedge clk); #1;
      check("to_busy_clear", 32'(busy), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
